// File: rtl/ct_ifu_icache_tag_ctrl.sv
// ---------------------------------------------------------------------------
// ct_ifu_icache_tag_ctrl
// Access controller for the 2-way I-cache tag SRAM. Arbitrates an
// invalidate-all sequencer, refill tag writes and fetch tag reads onto the
// single-port tag array, and registers the SRAM pins.
//
// Ports:
//   forever_cpuclk          clock
//   cpurst                  synchronous reset, active-high
//   cp0_ifu_icache_inv_req  invalidate-all request (level, sampled in IDLE)
//   ifu_tag_wr_req/idx/way/tag, ifu_tag_wr_ack   refill write channel
//   ifu_tag_rd_req/idx, ifu_tag_rd_grant         fetch read request channel
//   ifu_tag_rd_vld, ifu_tag_rd_data              read return (grant + 2)
//   icache_ifu_tag_dout     SRAM Q
//   ifu_icache_index, ifu_icache_tag_cen_b, ifu_icache_tag_wen,
//   ifu_icache_tag_din      registered SRAM pins
//   ifu_icache_tag_clk_en   tag clock local enable
//   ifu_tag_inv_busy/done   invalidate sequencer status
//
// Tag word: [58] LRU, [57:29] way1 {valid,tag}, [28:0] way0 {valid,tag}.
// ---------------------------------------------------------------------------
module ct_ifu_icache_tag_ctrl #(
    parameter int INDEX_W = 8
) (
    input  logic               forever_cpuclk,
    input  logic               cpurst,
    input  logic               cp0_ifu_icache_inv_req,
    input  logic               ifu_tag_wr_req,
    input  logic [INDEX_W-1:0] ifu_tag_wr_idx,
    input  logic               ifu_tag_wr_way,
    input  logic [27:0]        ifu_tag_wr_tag,
    output logic               ifu_tag_wr_ack,
    input  logic               ifu_tag_rd_req,
    input  logic [INDEX_W-1:0] ifu_tag_rd_idx,
    output logic               ifu_tag_rd_grant,
    output logic               ifu_tag_rd_vld,
    input  logic [58:0]        icache_ifu_tag_dout,
    output logic [58:0]        ifu_tag_rd_data,
    output logic [15:0]        ifu_icache_index,
    output logic               ifu_icache_tag_cen_b,
    output logic [2:0]         ifu_icache_tag_wen,
    output logic [58:0]        ifu_icache_tag_din,
    output logic               ifu_icache_tag_clk_en,
    output logic               ifu_tag_inv_busy,
    output logic               ifu_tag_inv_done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_INV  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam logic [INDEX_W-1:0] CNT_MAX = '1;

    logic [1:0]         r_state;
    logic [INDEX_W-1:0] r_cnt;
    logic               r_cen_b;
    logic [2:0]         r_wen;
    logic [15:0]        r_index;
    logic [58:0]        r_din;
    logic               r_rd_p1;
    logic               r_rd_vld;

    logic               w_inv_gnt;
    logic               w_wr_gnt;
    logic               w_rd_gnt;
    logic [58:0]        w_din_wr;
    logic [2:0]         w_wen_wr;
    logic               w_cen_b_next;
    logic [2:0]         w_wen_next;
    logic [15:0]        w_index_next;
    logic [58:0]        w_din_next;

    // Set index lands on address bits [INDEX_W+4:5]; the low 5 bits are the
    // line offset and are always zero on the tag array.
    function automatic logic [15:0] set_to_addr(input logic [INDEX_W-1:0] set);
        logic [15:0] addr;
        addr = '0;
        addr[INDEX_W+4:5] = set;
        return addr;
    endfunction

    // Grants are suppressed while reset is asserted so no ack escapes.
    assign w_inv_gnt = !cpurst && (r_state == ST_INV);
    assign w_wr_gnt  = !cpurst && (r_state == ST_IDLE) && ifu_tag_wr_req;
    assign w_rd_gnt  = !cpurst && (r_state == ST_IDLE) && !ifu_tag_wr_req && ifu_tag_rd_req;

    // Refill write: only the selected way field is enabled; LRU is always
    // written and points at the other way.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_way
            assign w_din_wr[gi*29 +: 29] = (ifu_tag_wr_way == 1'(gi)) ? {1'b1, ifu_tag_wr_tag} : 29'd0;
            assign w_wen_wr[gi]          = (ifu_tag_wr_way != 1'(gi));
        end
    endgenerate
    assign w_din_wr[58] = ~ifu_tag_wr_way;
    assign w_wen_wr[2]  = 1'b0;

    always_comb begin
        w_cen_b_next = 1'b1;
        w_wen_next   = 3'b111;
        w_index_next = r_index;
        w_din_next   = r_din;
        if (w_inv_gnt) begin
            w_cen_b_next = 1'b0;
            w_wen_next   = 3'b000;
            w_index_next = set_to_addr(r_cnt);
            w_din_next   = '0;
        end else if (w_wr_gnt) begin
            w_cen_b_next = 1'b0;
            w_wen_next   = w_wen_wr;
            w_index_next = set_to_addr(ifu_tag_wr_idx);
            w_din_next   = w_din_wr;
        end else if (w_rd_gnt) begin
            w_cen_b_next = 1'b0;
            w_index_next = set_to_addr(ifu_tag_rd_idx);
            w_din_next   = '0;
        end
    end

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_cen_b  <= 1'b1;
            r_wen    <= 3'b111;
            r_index  <= '0;
            r_din    <= '0;
            r_rd_p1  <= 1'b0;
            r_rd_vld <= 1'b0;
        end else begin
            r_cen_b  <= w_cen_b_next;
            r_wen    <= w_wen_next;
            r_index  <= w_index_next;
            r_din    <= w_din_next;
            r_rd_p1  <= w_rd_gnt;
            r_rd_vld <= r_rd_p1;
            case (r_state)
                ST_IDLE: if (cp0_ifu_icache_inv_req) r_state <= ST_INV;
                ST_INV: begin
                    if (r_cnt == CNT_MAX) begin
                        r_state <= ST_DONE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign ifu_tag_wr_ack        = w_wr_gnt;
    assign ifu_tag_rd_grant      = w_rd_gnt;
    assign ifu_tag_rd_vld        = r_rd_vld;
    assign ifu_tag_rd_data       = r_rd_vld ? icache_ifu_tag_dout : 59'd0;
    assign ifu_icache_index      = r_index;
    assign ifu_icache_tag_cen_b  = r_cen_b;
    assign ifu_icache_tag_wen    = r_wen;
    assign ifu_icache_tag_din    = r_din;
    // Enabled for the grant cycle, the SRAM access cycle and the output cycle.
    assign ifu_icache_tag_clk_en = w_inv_gnt | w_wr_gnt | w_rd_gnt | ~r_cen_b | r_rd_vld;
    assign ifu_tag_inv_busy      = (r_state != ST_IDLE);
    assign ifu_tag_inv_done      = (r_state == ST_DONE);

endmodule

// File: tb/tb_ct_ifu_icache_tag_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ct_ifu_icache_tag_ctrl
// Directed bench for the tag access controller: a vector table of single
// cycle grants with their pin images, plus sequences for read latency,
// write/read collision, invalidate-all and reset during invalidate. A small
// tag SRAM model closes the loop so read data reflects earlier writes.
// ---------------------------------------------------------------------------
module tb_ct_ifu_icache_tag_ctrl;

    logic        clk = 1'b0;
    logic        cpurst;
    logic        inv_req;
    logic        wr_req;
    logic [7:0]  wr_idx;
    logic        wr_way;
    logic [27:0] wr_tag;
    logic        wr_ack;
    logic        rd_req;
    logic [7:0]  rd_idx;
    logic        rd_grant;
    logic        rd_vld;
    logic [58:0] dout;
    logic [58:0] rd_data;
    logic [15:0] index;
    logic        cen_b;
    logic [2:0]  wen;
    logic [58:0] din;
    logic        clk_en;
    logic        inv_busy;
    logic        inv_done;

    int total = 0;
    int bad   = 0;

    localparam logic [58:0] PRELOAD = 59'h3A5_1234_5678_9ABC;

    always #5 clk = ~clk;

    ct_ifu_icache_tag_ctrl #(.INDEX_W(8)) dut (
        .forever_cpuclk        (clk),
        .cpurst                (cpurst),
        .cp0_ifu_icache_inv_req(inv_req),
        .ifu_tag_wr_req        (wr_req),
        .ifu_tag_wr_idx        (wr_idx),
        .ifu_tag_wr_way        (wr_way),
        .ifu_tag_wr_tag        (wr_tag),
        .ifu_tag_wr_ack        (wr_ack),
        .ifu_tag_rd_req        (rd_req),
        .ifu_tag_rd_idx        (rd_idx),
        .ifu_tag_rd_grant      (rd_grant),
        .ifu_tag_rd_vld        (rd_vld),
        .icache_ifu_tag_dout   (dout),
        .ifu_tag_rd_data       (rd_data),
        .ifu_icache_index      (index),
        .ifu_icache_tag_cen_b  (cen_b),
        .ifu_icache_tag_wen    (wen),
        .ifu_icache_tag_din    (din),
        .ifu_icache_tag_clk_en (clk_en),
        .ifu_tag_inv_busy      (inv_busy),
        .ifu_tag_inv_done      (inv_done)
    );

    // Tag SRAM model: per-field active-low write enables, registered Q.
    logic        preload;
    logic [58:0] mem [0:255];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
            mem[8'h3A] <= PRELOAD;
            dout <= '0;
        end else if (!cen_b) begin
            if (!wen[0]) mem[index[12:5]][28:0]  <= din[28:0];
            if (!wen[1]) mem[index[12:5]][57:29] <= din[57:29];
            if (!wen[2]) mem[index[12:5]][58]    <= din[58];
            if (wen == 3'b111) dout <= mem[index[12:5]];
        end
    end

    typedef struct {
        logic        wr_req;
        logic [7:0]  wr_idx;
        logic        wr_way;
        logic [27:0] wr_tag;
        logic        rd_req;
        logic [7:0]  rd_idx;
        logic        exp_ack;
        logic        exp_grant;
        logic        exp_cen_b;
        logic [2:0]  exp_wen;
        logic [15:0] exp_index;
        logic [58:0] exp_din;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        inv_req = 0; wr_req = 0; wr_idx = 0; wr_way = 0; wr_tag = 0;
        rd_req = 0; rd_idx = 0;
    endtask

    logic [58:0] exp_word;

    initial begin
        cpurst = 1; preload = 1;
        idle_inputs();

        // Table: one request per cycle; grant checked in-cycle, pins next cycle.
        vecs[0] = '{0, 8'h00, 0, 28'h0,       1, 8'h3A, 0, 1, 0, 3'b111, 16'h0740, 59'h0};
        vecs[1] = '{1, 8'h05, 1, 28'hABCDEF1, 0, 8'h00, 1, 0, 0, 3'b001, 16'h00A0,
                    {1'b0, 1'b1, 28'hABCDEF1, 29'h0}};
        vecs[2] = '{1, 8'hFF, 0, 28'h1234567, 0, 8'h00, 1, 0, 0, 3'b010, 16'h1FE0,
                    {1'b1, 29'h0, 1'b1, 28'h1234567}};
        vecs[3] = '{0, 8'h00, 0, 28'h0,       0, 8'h00, 0, 0, 1, 3'b111, 16'h1FE0,
                    {1'b1, 29'h0, 1'b1, 28'h1234567}};
        vecs[4] = '{1, 8'h10, 0, 28'h0000001, 1, 8'h10, 1, 0, 0, 3'b010, 16'h0200,
                    {1'b1, 29'h0, 1'b1, 28'h0000001}};
        vecs[5] = '{0, 8'h00, 0, 28'h0,       1, 8'h00, 0, 1, 0, 3'b111, 16'h0000, 59'h0};
        vecs[6] = '{0, 8'h00, 0, 28'h0,       0, 8'h00, 0, 0, 1, 3'b111, 16'h0000, 59'h0};

        // 1. Reset state
        tick(); tick();
        chk("rst_cen_b", cen_b, 1);
        chk("rst_wen", wen, 3'b111);
        chk("rst_index", index, 0);
        chk("rst_din", din, 0);
        chk("rst_clk_en", clk_en, 0);
        chk("rst_busy", inv_busy, 0);
        chk("rst_done", inv_done, 0);
        chk("rst_rd_vld", rd_vld, 0);
        cpurst = 0; preload = 0;
        tick();

        // 2. Read latency: grant at 0, pins at 1, vld at 2
        rd_req = 1; rd_idx = 8'h3A; #1;
        chk("rd_grant_c0", rd_grant, 1);
        chk("rd_clk_en_c0", clk_en, 1);
        tick(); rd_req = 0; #1;
        chk("rd_index_c1", index, 16'h0740);
        chk("rd_cen_c1", cen_b, 0);
        chk("rd_wen_c1", wen, 3'b111);
        chk("rd_vld_c1", rd_vld, 0);
        chk("rd_data_c1", rd_data, 0);
        tick();
        chk("rd_vld_c2", rd_vld, 1);
        chk("rd_data_c2", rd_data, PRELOAD);
        chk("rd_clk_en_c2", clk_en, 1);
        tick();
        chk("rd_vld_c3", rd_vld, 0);
        chk("rd_clk_en_c3", clk_en, 0);

        // Vector table
        for (int i = 0; i < 7; i++) begin
            wr_req = vecs[i].wr_req; wr_idx = vecs[i].wr_idx;
            wr_way = vecs[i].wr_way; wr_tag = vecs[i].wr_tag;
            rd_req = vecs[i].rd_req; rd_idx = vecs[i].rd_idx;
            #1;
            chk($sformatf("v%0d_ack", i), wr_ack, vecs[i].exp_ack);
            chk($sformatf("v%0d_grant", i), rd_grant, vecs[i].exp_grant);
            tick();
            idle_inputs();
            chk($sformatf("v%0d_cen_b", i), cen_b, vecs[i].exp_cen_b);
            chk($sformatf("v%0d_wen", i), wen, vecs[i].exp_wen);
            chk($sformatf("v%0d_index", i), index, vecs[i].exp_index);
            chk($sformatf("v%0d_din", i), din, vecs[i].exp_din);
        end
        tick(); tick();

        // 4. Write and read to the same set: write first, read returns new data
        wr_req = 1; wr_idx = 8'h10; wr_way = 1; wr_tag = 28'hBEEF123;
        rd_req = 1; rd_idx = 8'h10; #1;
        chk("col_ack_c0", wr_ack, 1);
        chk("col_grant_c0", rd_grant, 0);
        tick(); wr_req = 0; #1;
        chk("col_grant_c1", rd_grant, 1);
        tick(); rd_req = 0; #1;
        chk("col_vld_c2", rd_vld, 0);
        tick();
        exp_word = {1'b0, 1'b1, 28'hBEEF123, 1'b1, 28'h0000001};
        chk("col_vld_c3", rd_vld, 1);
        chk("col_data_c3", rd_data, exp_word);
        tick(); tick();

        // 5. Invalidate-all with a read waiting throughout
        inv_req = 1; #1;
        chk("inv_busy_c0", inv_busy, 0);
        for (int c = 1; c <= 258; c++) begin
            tick();
            inv_req = 0;
            if (c == 1) begin rd_req = 1; rd_idx = 8'h10; end
            #1;
            chk($sformatf("inv_busy_c%0d", c), inv_busy, (c <= 257));
            chk($sformatf("inv_done_c%0d", c), inv_done, (c == 257));
            chk($sformatf("inv_grant_c%0d", c), rd_grant, (c == 258));
            if (c >= 2 && c <= 257) begin
                chk($sformatf("inv_cen_c%0d", c), cen_b, 0);
                chk($sformatf("inv_wen_c%0d", c), wen, 3'b000);
                chk($sformatf("inv_din_c%0d", c), din, 0);
                chk($sformatf("inv_index_c%0d", c), index, 16'((c - 2) << 5));
            end
        end
        tick(); rd_req = 0;
        tick();
        chk("inv_rd_vld", rd_vld, 1);
        chk("inv_rd_data", rd_data, 0);
        tick(); tick();

        // 6. Reset during invalidate, then restart from set 0
        inv_req = 1;
        for (int c = 1; c <= 100; c++) begin
            tick();
            inv_req = 0;
            #1;
            chk($sformatf("rinv_done_c%0d", c), inv_done, 0);
        end
        chk("rinv_index_c100", index, 16'((98) << 5));
        cpurst = 1;
        tick();
        cpurst = 0; #1;
        chk("rinv_busy", inv_busy, 0);
        chk("rinv_cen_b", cen_b, 1);
        chk("rinv_wen", wen, 3'b111);
        chk("rinv_done", inv_done, 0);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk($sformatf("rinv_idle_busy%0d", c), inv_busy, 0);
            chk($sformatf("rinv_idle_done%0d", c), inv_done, 0);
        end
        inv_req = 1; #1;
        for (int c = 1; c <= 258; c++) begin
            tick();
            inv_req = 0;
            #1;
            chk($sformatf("rst2_done_c%0d", c), inv_done, (c == 257));
            if (c == 2) begin
                chk("rst2_index_c2", index, 16'h0000);
                chk("rst2_wen_c2", wen, 3'b000);
            end
            if (c == 3) chk("rst2_index_c3", index, 16'h0020);
        end
        chk("rst2_busy_end", inv_busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
